instruction_memory: RTL and testbench

- Word-addressed instruction memory for the single-cycle MIPS datapath; it sits between the PC and the instruction decoder.
- Read path is purely combinational: RD follows A within the same cycle.
- Contents are held in a register array. Asynchronous reset restores a built-in default program.
- A synchronous load port lets a testbench or boot logic overwrite words.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_addr_check.sv | 14 +
 rtl/instruction_memory.sv | 63 ++++++
 tb/tb_instruction_memory.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and default program for the MIPS instruction memory.
package imem_pkg;

    localparam int          IMEM_DEPTH = 64;
    localparam logic [31:0] IMEM_NOP   = 32'h0000_0000;

    // Boot program: addi/add/sw/lw/beq loop ending in a jump back to 0.
    function automatic logic [31:0] imem_default_word(input logic [29:0] idx);
        logic [31:0] w;
        w = IMEM_NOP;
        unique case (idx)
            30'd0:   w = 32'h2008_0005;
            30'd1:   w = 32'h2009_000A;
            30'd2:   w = 32'h0109_5020;
            30'd3:   w = 32'hAC0A_0000;
            30'd4:   w = 32'h8C0B_0000;
            30'd5:   w = 32'h110B_0001;
            30'd6:   w = 32'h0800_0000;
            default: w = IMEM_NOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Range and word-alignment check for a byte address into the instruction memory.
module imem_addr_check #(
    parameter int AW = 6
) (
    input  logic [31:0] addr,
    output logic        in_range,
    output logic        addr_err
);

    // Power-of-two depth: in range exactly when no bit above the index is set.
    assign in_range = ~|addr[31:AW+2];
    assign addr_err = ~in_range | (|addr[1:0]);

endmodule

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with combinational read and reset-loaded program.
// IMEM_LOAD_EN enables the synchronous load port; otherwise the contents are ROM.
module instruction_memory
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    output logic [31:0] RD,
    output logic        addr_err,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    logic          rd_in_range;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign rd_idx = A[AW+1:2];

    imem_addr_check #(.AW(AW)) u_rd_check (
        .addr     (A),
        .in_range (rd_in_range),
        .addr_err (addr_err)
    );

`ifdef IMEM_LOAD_EN
    logic [31:0] mem [DEPTH];
    logic        ld_in_range;
    logic        ld_err_unused;

    imem_addr_check #(.AW(AW)) u_ld_check (
        .addr     (load_addr),
        .in_range (ld_in_range),
        .addr_err (ld_err_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= imem_default_word(30'(i));
            end
        end else if (load_we && ld_in_range) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    assign rd_word = mem[rd_idx];
`else
    logic unused_load;

    assign unused_load = ^{clk, rst_n, load_we, load_addr, load_data};
    assign rd_word     = imem_default_word(30'(rd_idx));
`endif

    // No wrap-around: anything past the end fetches a NOP.
    assign RD = rd_in_range ? rd_word : IMEM_NOP;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized scoreboard bench for instruction_memory against an array model.
module tb_instruction_memory;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] RD;
    logic        addr_err;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    instruction_memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .RD        (RD),
        .addr_err  (addr_err),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    event        sample_ev;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [DEPTH];

    function automatic logic [31:0] boot_word(input int w);
        case (w)
            0: return 32'h20080005;
            1: return 32'h2009000A;
            2: return 32'h01095020;
            3: return 32'hAC0A0000;
            4: return 32'h8C0B0000;
            5: return 32'h110B0001;
            6: return 32'h08000000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int w = 0; w < DEPTH; w++) model[w] = boot_word(w);
    endtask

    task automatic model_write(input logic we, input logic [31:0] ad,
                               input logic [31:0] d);
`ifdef IMEM_LOAD_EN
        if (we && (ad >> 2) < DEPTH) model[ad >> 2] = d;
`else
        if (we) model[0] = model[0];
`endif
    endtask

    task automatic expect_read(input string nm);
        exp_t        e;
        logic [31:0] w;
        w     = A >> 2;
        e.rd  = (w < DEPTH) ? model[w] : 32'h0;
        e.err = (w >= DEPTH) || (A % 4 != 0);
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->sample_ev;
        #1;
    endtask

    initial begin
        exp_t  e;
        string n;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (RD !== e.rd || addr_err !== e.err) begin
                    errors++;
                    $display("FAIL %s A=%h: got RD=%h err=%b, want RD=%h err=%b",
                             n, A, RD, addr_err, e.rd, e.err);
                end
            end
        end
    end

    initial begin
        logic [31:0] dir_a [12];
        dir_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                  32'h18, 32'h20, 32'h30, 32'h1000, 32'h100, 32'h06};

        rst_n     = 1'b1;
        A         = 32'h0;
        load_we   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 expect_read("in_reset");
        @(negedge clk) rst_n = 1'b1;

        foreach (dir_a[i]) begin
            A = dir_a[i];
            #1 expect_read("sweep");
        end

        // Load into word 8, holding A across the edge.
        @(negedge clk);
        A = 32'h20; load_we = 1'b1; load_addr = 32'h20; load_data = 32'hDEADBEEF;
        #1 expect_read("pre_edge");
        @(posedge clk);
        model_write(1'b1, 32'h20, 32'hDEADBEEF);
        #1 expect_read("post_edge");

        @(negedge clk);
        load_addr = 32'h1000; load_data = 32'hCAFEF00D;
        @(posedge clk);
        model_write(1'b1, 32'h1000, 32'hCAFEF00D);
        #1;
        load_we = 1'b0;
        for (int w = 0; w < 10; w++) begin
            A = w * 4;
            #1 expect_read("oor_write");
        end

        // Asynchronous reset between edges with a competing write.
        @(negedge clk);
        A = 32'h20; load_we = 1'b1; load_addr = 32'h20; load_data = 32'h12345678;
        #2 rst_n = 1'b0;
        model_reset();
        #1 expect_read("async_rst");
        @(posedge clk);
        #1 expect_read("rst_blocks_we");
        @(negedge clk);
        rst_n = 1'b1; load_we = 1'b0;
        #1 expect_read("after_rst");

        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            load_we   = ($urandom_range(0, 1) == 1);
            load_data = $urandom;
            case ($urandom_range(0, 3))
                0: load_addr = {24'h0, 2'b00, 6'($urandom_range(0, 63))} << 2;
                1: load_addr = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
                2: load_addr = $urandom | 32'h0000_0100;
                default: load_addr = $urandom_range(64, 70) << 2;
            endcase
            case ($urandom_range(0, 3))
                0: A = load_addr;
                1: A = $urandom_range(0, 63) << 2;
                2: A = $urandom_range(0, 300);
                default: A = $urandom;
            endcase
            #1 expect_read("rand_pre");
            @(posedge clk);
            model_write(load_we, load_addr, load_data);
            #1 expect_read("rand_post");
        end

        @(negedge clk) load_we = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            A = w * 4;
            #1 expect_read("final_sweep");
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) #1;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
